// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
//
// Synchronous instruction memory with a request/response fetch port. It sits
// between the fetch stage and program storage. The core stalls while a fetch
// is in flight.
//
// A fetch is accepted in IDLE. The word is read at the accept edge, and the
// FSM then waits WAIT_STATES cycles. The response is held in RESP until the
// consumer takes it. Misaligned or out-of-range addresses return a zero word
// with rsp_fault set. A load port writes words at run time, in any state.
//
// Optional feature macro: IMEM_PARITY_EN
//   When it is defined, every word stores an even-parity bit that is computed
//   on load. The bit is recomputed at accept, and a mismatch raises
//   rsp_parity_err. When it is undefined, rsp_parity_err is tied to 0.
//
// Parameters:
//   DATA_W      instruction word width
//   ADDR_W      byte-address width of req_addr
//   DEPTH       number of words (need not be a power of two)
//   IDX_W       word-index width
//   WAIT_STATES extra cycles before a response (0..7)
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   req_valid      in   fetch request
//   req_ready      out  request can be accepted (IDLE and not in reset)
//   req_addr       in   byte address of the instruction
//   rsp_valid      out  response available (RESP state)
//   rsp_ready      in   consumer takes the response
//   rsp_data       out  fetched word (0 on fault)
//   rsp_fault      out  request was misaligned or out of range
//   rsp_parity_err out  stored-parity mismatch on the fetched word
//   ld_en          in   load-port write strobe
//   ld_idx         in   word index to write
//   ld_data        in   word to write
//   busy           out  a request is in flight
// -----------------------------------------------------------------------------
module imem_fetch_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned IDX_W       = $clog2(DEPTH),
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_fault,
  output logic              rsp_parity_err,
  input  logic              ld_en,
  input  logic [IDX_W-1:0]  ld_idx,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  // ---------------------------------------------------------------------------
  // FSM encoding
  // ---------------------------------------------------------------------------
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  // The last count value in WAIT. It is unused when WAIT_STATES == 0, because
  // WAIT is then unreachable.
  localparam logic [2:0] WaitLast = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // Memory contents are deliberately not reset.
  logic [DATA_W-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // State and response registers
  // ---------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [2:0]        r_cnt;
  logic [2:0]        w_cnt_next;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_fault;
  logic              r_rsp_parity_err;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic                w_accept;
  logic [IDX_W-1:0]    w_idx;
  logic [ADDR_W-3:0]   w_word_addr;
  logic                w_misaligned;
  logic                w_out_of_range;
  logic                w_fault;
  logic                w_parity_err;
  logic                w_ld_fire;

  assign req_ready = (r_state == StIdle) && !rst;
  assign w_accept  = req_valid && req_ready;

  assign w_idx          = req_addr[IDX_W+1:2];
  assign w_word_addr    = req_addr[ADDR_W-1:2];
  assign w_misaligned   = (req_addr[1:0] != 2'b00);
  // The range check uses the full word address. Upper address bits that
  // alias into the index range still fault.
  assign w_out_of_range = (64'(w_word_addr) >= 64'(DEPTH));
  assign w_fault        = w_misaligned || w_out_of_range;

  // A load is dropped under reset, and an index past the end is ignored.
  assign w_ld_fire = ld_en && !rst && (64'(ld_idx) < 64'(DEPTH));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_cnt_next   = 3'd0;
          w_state_next = (WAIT_STATES > 0) ? StWait : StResp;
        end
      end
      StWait: begin
        if (r_cnt == WaitLast) begin
          w_cnt_next   = 3'd0;
          w_state_next = StResp;
        end else begin
          w_cnt_next = r_cnt + 3'd1;
        end
      end
      StResp: begin
        // rsp_ready in earlier states is ignored. Only the RESP handshake
        // ends the fetch.
        if (rsp_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional parity
  // ---------------------------------------------------------------------------
`ifdef IMEM_PARITY_EN
  logic r_par [DEPTH];

  // Even parity: the stored bit makes the total count of ones even.
  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      r_par[ld_idx] <= ^ld_data;
    end
  end

  // A faulted request never reads storage, so it cannot report a parity error.
  assign w_parity_err = !w_fault && ((^r_mem[w_idx]) != r_par[w_idx]);
`else
  assign w_parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Memory write port
  // ---------------------------------------------------------------------------
  // The read at accept and a same-edge load use non-blocking semantics. The
  // response therefore carries the old word (read-before-write).
  always_ff @(posedge clk) begin
    if (w_ld_fire) begin
      r_mem[ld_idx] <= ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and response capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= StIdle;
      r_cnt            <= 3'd0;
      r_rsp_data       <= '0;
      r_rsp_fault      <= 1'b0;
      r_rsp_parity_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      // The response is captured only at accept. It stays stable through
      // WAIT and RESP, even when a later load hits the same index.
      if (w_accept) begin
        r_rsp_data       <= w_fault ? '0 : r_mem[w_idx];
        r_rsp_fault      <= w_fault;
        r_rsp_parity_err <= w_parity_err;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rsp_valid      = (r_state == StResp);
  assign busy           = (r_state != StIdle);
  assign rsp_data       = r_rsp_data;
  assign rsp_fault      = r_rsp_fault;
  assign rsp_parity_err = r_rsp_parity_err;

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

  localparam int unsigned DataW  = 32;
  localparam int unsigned AddrW  = 32;
  localparam int unsigned Depth  = 1024;
  localparam int unsigned IdxW   = 10;
  localparam int unsigned Ws     = 1;
  localparam int unsigned Loaded = 16;  // indices 0..Loaded-1 are always defined

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [AddrW-1:0]  req_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DataW-1:0]  rsp_data;
  logic              rsp_fault;
  logic              rsp_parity_err;
  logic              ld_en;
  logic [IdxW-1:0]   ld_idx;
  logic [DataW-1:0]  ld_data;
  logic              busy;

  imem_fetch_unit #(
    .DATA_W      (DataW),
    .ADDR_W      (AddrW),
    .DEPTH       (Depth),
    .WAIT_STATES (Ws)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_fault      (rsp_fault),
    .rsp_parity_err (rsp_parity_err),
    .ld_en          (ld_en),
    .ld_idx         (ld_idx),
    .ld_data        (ld_data),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference memory. It is updated only by loads the bench itself performs.
  logic [31:0] m_mem [Depth];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One load-port write, presented for a single cycle.
  task automatic load(input int idx, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_idx  = IdxW'(idx);
    ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
    if (!rst && idx < int'(Depth)) m_mem[idx] = data;
  endtask

  // One complete fetch transaction. The expected response comes from the
  // model memory before any same-edge or later load is applied.
  task automatic fetch(input logic [31:0] a, input int hold, input bit early,
                       input bit ld_same, input logic [31:0] ld_d, input bit ld_late,
                       input bit exp_perr);
    bit          fault;
    int          idx;
    logic [31:0] exp;
    fault = (a[1:0] != 2'b00) || ((a >> 2) >= 32'(Depth));
    idx   = int'((a >> 2) % 32'(Depth));
    exp   = fault ? 32'h0 : m_mem[idx];
    check_eq("idle_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    if (ld_same) begin
      ld_en   = 1'b1;
      ld_idx  = IdxW'(idx);
      ld_data = ld_d;
    end
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    ld_en     = 1'b0;
    if (ld_same) m_mem[idx] = ld_d;
    for (int k = 0; k < int'(Ws); k++) begin
      check_eq("wait_valid", 32'(rsp_valid), 32'd0);
      check_eq("wait_busy", 32'(busy), 32'd1);
      check_eq("wait_ready", 32'(req_ready), 32'd0);
      rsp_ready = early;
      if (ld_late && !fault) begin
        ld_en   = 1'b1;
        ld_idx  = IdxW'(idx);
        ld_data = ~exp;
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      if (ld_late && !fault) begin
        ld_en      = 1'b0;
        m_mem[idx] = ~exp;
      end
    end
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_data", rsp_data, exp);
    check_eq("rsp_fault", 32'(rsp_fault), 32'(fault));
    check_eq("rsp_perr", 32'(rsp_parity_err), 32'(exp_perr));
    check_eq("rsp_busy", 32'(busy), 32'd1);
    check_eq("rsp_req_ready", 32'(req_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold_data", rsp_data, exp);
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("post_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int          kind;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    ld_idx    = '0;
    ld_data   = '0;
    for (int i = 0; i < int'(Depth); i++) m_mem[i] = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_data", rsp_data, 32'd0);
    check_eq("rst_fault", 32'(rsp_fault), 32'd0);
    check_eq("rst_perr", 32'(rsp_parity_err), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(req_ready), 32'd1);

    // Program preload
    load(0, 32'h00500c63);
    load(1, 32'h00002083);
    load(2, 32'h01402103);
    for (int i = 3; i < int'(Loaded); i++) load(i, $urandom);

    // Directed cases
    fetch(32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch(32'h4, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch(32'h6, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch(32'h1000, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch(32'h4, 5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch(32'h8, 0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    fetch(32'h8, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch(32'h8, 1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Reset one cycle into WAIT aborts the fetch. A load during reset is dropped.
    req_valid = 1'b1;
    req_addr  = 32'h4;
    @(negedge clk);
    req_valid = 1'b0;
    check_eq("abort_in_wait", 32'(busy), 32'd1);
    rst     = 1'b1;
    ld_en   = 1'b1;
    ld_idx  = '0;
    ld_data = 32'h12345678;
    @(negedge clk);
    ld_en = 1'b0;
    check_eq("abort_valid", 32'(rsp_valid), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_data", rsp_data, 32'd0);
    check_eq("abort_fault", 32'(rsp_fault), 32'd0);
    check_eq("abort_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;
    fetch(32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

`ifdef IMEM_PARITY_EN
    // Corrupt one stored data bit behind the load port.
    dut.r_mem[3] = dut.r_mem[3] ^ 32'h0000_0010;
    m_mem[3]     = m_mem[3] ^ 32'h0000_0010;
    fetch(32'hC, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    fetch(32'h10, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    load(3, $urandom);
    fetch(32'hC, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`endif

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        a = ($urandom_range(0, Loaded - 1) << 2) | $urandom_range(1, 3);
      end else if (kind == 1) begin
        a = $urandom_range(Depth, 4 * Depth) << 2;
      end else if (kind == 2) begin
        a = $urandom | 32'h8000_0000;
      end else begin
        a = $urandom_range(0, Loaded - 1) << 2;
      end
      if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, Loaded - 1)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("idle_rsp_ready", 32'(rsp_valid), 32'd0);
      end
      fetch(a, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
